// File: rtl/adpcm_pkg.sv
// adpcm_pkg: definitions shared by the ADPCM datapath blocks (filtez, upzero, ...).
//   state_e       : one-hot block-level FSM encoding
//   FILTEZ_TAPS   : coefficient/history pairs summed by filtez
//   FILTEZ_SHIFT  : accumulator scaling shift applied by filtez
//   ARRAY_ADDR_W  : address width of the bli/dlti arrays, shared with upzero
package adpcm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RD   = 4'b0010,
    ST_MAC  = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  localparam int unsigned FILTEZ_TAPS  = 6;
  localparam int unsigned FILTEZ_SHIFT = 14;
  localparam int unsigned ARRAY_ADDR_W = 3;

endpackage

// File: rtl/filtez_mac.sv
// filtez_mac: 64-bit signed multiply-accumulate register.
//   ap_clk : clock
//   clr    : synchronous clear of the accumulator (has priority over en)
//   en     : add a*b to the accumulator this cycle
//   a, b   : signed 32-bit operands
//   acc    : accumulator, wraps modulo 2^64
module filtez_mac (
  input  logic        ap_clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod;
  logic        [63:0] acc_q;

  // Low 64 bits of the 64x64 product equal the exact signed 32x32 product.
  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge ap_clk) begin
    if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + prod;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/filtez.sv
// filtez: zero-section predictor filter. Sums bli[k]*dlti[k] over N_TAPS taps
// read from two single-port RAMs and returns the 64-bit sum scaled by 2^-SHIFT.
//   ap_clk, ap_rst                : clock, synchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready : block-level handshake
//   bli_address0/ce0, bli_q0      : coefficient RAM port (1-cycle read latency)
//   dlti_address0/ce0, dlti_q0    : history RAM port (1-cycle read latency)
//   ap_return                     : registered result, held until the next DONE
module filtez
  import adpcm_pkg::*;
#(
  parameter int unsigned N_TAPS = FILTEZ_TAPS,
  parameter int unsigned SHIFT  = FILTEZ_SHIFT
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic [ARRAY_ADDR_W-1:0] bli_address0,
  output logic                    bli_ce0,
  input  logic [31:0]             bli_q0,
  output logic [ARRAY_ADDR_W-1:0] dlti_address0,
  output logic                    dlti_ce0,
  input  logic [31:0]             dlti_q0,
  output logic [31:0]             ap_return
);

  localparam int unsigned CNT_W = $clog2(N_TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [31:0]      ret_q;
  logic [63:0]      acc;
  logic             mac_clr;
  logic             mac_en;
  logic             rd_issue;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ap_start) state_d = ST_RD;
      ST_RD:   state_d = (i_q == LAST_TAP) ? ST_DONE : ST_MAC;
      ST_MAC:  state_d = ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    rd_issue = 1'b0;
    mac_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: ap_idle = ~ap_start;
      ST_RD:   rd_issue = (i_q != LAST_TAP);
      ST_MAC:  mac_en = 1'b1;
      ST_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Tap counter: cleared in IDLE, advanced once per MAC
  always_comb begin
    i_d = i_q;
    if (state_q == ST_IDLE) begin
      i_d = '0;
    end else if (state_q == ST_MAC) begin
      i_d = i_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      i_q   <= '0;
      ret_q <= '0;
    end else begin
      i_q <= i_d;
      // Low 32 bits of acc >> SHIFT are acc[SHIFT+31:SHIFT]: arithmetic shift, floor rounding.
      if (state_q == ST_DONE) ret_q <= 32'(acc >> SHIFT);
    end
  end

  // RAM data are consumed straight from q0 in MAC, one cycle after the RD request.
  assign mac_clr = ap_rst | (state_q == ST_IDLE);

  filtez_mac u_mac (
    .ap_clk (ap_clk),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (bli_q0),
    .b      (dlti_q0),
    .acc    (acc)
  );

  assign bli_address0  = ARRAY_ADDR_W'(i_q);
  assign dlti_address0 = ARRAY_ADDR_W'(i_q);
  assign bli_ce0       = rd_issue;
  assign dlti_ce0      = rd_issue;
  assign ap_return     = ret_q;

endmodule

// File: tb/tb_filtez.sv
module tb_filtez;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [2:0]  bli_address0, dlti_address0;
  logic        bli_ce0, dlti_ce0;
  logic [31:0] bli_q0, dlti_q0;
  logic [31:0] ap_return;

  int bli_mem  [8];
  int dlti_mem [8];

  int n_total = 0;
  int n_pass  = 0;
  int cyc_cnt = 0;
  bit chk_en  = 1'b0;

  // Reference model state: run position counted in cycles since start acceptance.
  bit m_busy    = 1'b0;
  int m_cyc     = 0;
  int m_pending = 0;
  int m_ret     = 0;

  filtez dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .bli_address0  (bli_address0),
    .bli_ce0       (bli_ce0),
    .bli_q0        (bli_q0),
    .dlti_address0 (dlti_address0),
    .dlti_ce0      (dlti_ce0),
    .dlti_q0       (dlti_q0),
    .ap_return     (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc_cnt <= cyc_cnt + 1;

  // Single-port RAMs, one cycle read latency
  always @(posedge ap_clk) begin
    if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
    if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
  end

  function automatic int model_ret();
    longint acc = 0;
    for (int k = 0; k < 6; k++) acc += longint'(bli_mem[k]) * longint'(dlti_mem[k]);
    return int'(acc >>> 14);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                  name, $signed(act), act, $signed(exp), exp, cyc_cnt);
  endtask

  // Model: start accepted in cycle 0, reads on odd cycles 1..11, DONE in cycle 14.
  always @(posedge ap_clk) begin
    if (ap_rst) begin
      m_busy = 1'b0;
      m_ret  = 0;
    end else if (!m_busy) begin
      if (ap_start) begin
        m_busy    = 1'b1;
        m_cyc     = 1;
        m_pending = model_ret();
      end
    end else if (m_cyc == 14) begin
      m_busy = 1'b0;
      m_ret  = m_pending;
    end else begin
      m_cyc++;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      bit m_done, m_ce;
      m_done = m_busy && (m_cyc == 14);
      m_ce   = m_busy && (m_cyc % 2 == 1) && (m_cyc <= 11);
      chk("ap_done", 32'(ap_done), 32'(m_done));
      chk("ap_ready", 32'(ap_ready), 32'(m_done));
      chk("ap_idle", 32'(ap_idle), 32'(!m_busy && !ap_start));
      chk("bli_ce0", 32'(bli_ce0), 32'(m_ce));
      chk("dlti_ce0", 32'(dlti_ce0), 32'(m_ce));
      chk("ap_return", ap_return, m_ret);
      if (m_ce) begin
        chk("bli_address0", 32'(bli_address0), (m_cyc - 1) / 2);
        chk("dlti_address0", 32'(dlti_address0), (m_cyc - 1) / 2);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Waits for ap_done; lat = cycles since cycle t0, or -1 on timeout.
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ap_done) begin
        lat = cyc_cnt - t0;
        break;
      end
    end
  endtask

  task automatic run_one(input string name, input int exp_ret);
    int t0, lat;
    tick();
    ap_start = 1'b1;
    t0 = cyc_cnt;
    tick();
    ap_start = 1'b0;
    wait_done(t0, lat);
    chk({name, "_latency"}, lat, 14);
    tick();
    chk(name, ap_return, exp_ret);
  endtask

  task automatic fill(input int b, input int d);
    for (int k = 0; k < 8; k++) begin
      bli_mem[k]  = b;
      dlti_mem[k] = d;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1) == 1) begin
        bli_mem[k]  = int'($urandom);
        dlti_mem[k] = int'($urandom);
      end else begin
        bli_mem[k]  = $urandom_range(65535) - 32768;
        dlti_mem[k] = $urandom_range(65535) - 32768;
      end
    end
  endtask

  initial begin
    int t0, lat;
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    fill(0, 0);
    tick();
    chk_en = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("reset_idle", 32'(ap_idle), 32'd1);
    chk("reset_return", ap_return, 32'd0);

    // Zero coefficients; unused entries 6/7 poisoned to catch over-reads
    for (int k = 0; k < 6; k++) begin
      bli_mem[k]  = 0;
      dlti_mem[k] = k + 1;
    end
    bli_mem[6] = 99999; dlti_mem[6] = 77777;
    bli_mem[7] = -5555; dlti_mem[7] = 1234567;
    run_one("zero_bli", 0);

    for (int k = 0; k < 6; k++) begin
      bli_mem[k]  = 16384;
      dlti_mem[k] = k + 1;
    end
    run_one("ramp", 21);

    for (int k = 1; k < 6; k++) begin
      bli_mem[k]  = 0;
      dlti_mem[k] = 0;
    end
    bli_mem[0] = -32768; dlti_mem[0] = 16384;
    run_one("neg_big", -32768);
    bli_mem[0] = -1; dlti_mem[0] = 1;
    run_one("neg_floor", -1);

    fill(1 << 20, 1 << 20);
    run_one("wide64", 402653184);

    // Reset mid-run at cycle 7: no done, result forced to 0, fresh run works
    for (int k = 0; k < 6; k++) begin
      bli_mem[k]  = 16384;
      dlti_mem[k] = k + 1;
    end
    tick();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (6) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("rst_mid_idle", 32'(ap_idle), 32'd1);
    chk("rst_mid_return", ap_return, 32'd0);
    repeat (16) tick();
    run_one("rst_fresh", 21);

    // Held start: three back-to-back runs, RAM rewritten in each DONE cycle
    fill_rand();
    tick();
    ap_start = 1'b1;
    t0 = cyc_cnt;
    for (int r = 0; r < 3; r++) begin
      wait_done(t0, lat);
      chk("held_latency", lat, 14 + 15 * r);
      fill_rand();
      if (r == 2) ap_start = 1'b0;
    end
    tick();

    // Randomized runs with random gaps and occasional held start
    for (int r = 0; r < 20; r++) begin
      fill_rand();
      repeat ($urandom_range(3)) tick();
      ap_start = 1'b1;
      t0 = cyc_cnt;
      tick();
      if ($urandom_range(3) != 0) ap_start = 1'b0;
      wait_done(t0, lat);
      chk("rand_latency", lat, 14);
      ap_start = 1'b0;
      tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
